instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  PC register and instruction-fetch front end. Issues word reads to instruction memory via valid/ready.
//  Buffers returned words with their PC in a small FIFO.
//  Presents them to the decode/control stage through a valid/ready handshake.
//  Consumes the branch/jump redirect produced downstream (PCSel + target) and flushes wrong-path work.
// PARAMETERS
//  n          32            datapath/address width
//  RESET_PC   32'h0000_0000 first fetch address after reset
//  BUF_DEPTH  2             instruction buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1  clock, all state on rising edge
//  rst             in   1  synchronous reset, active-high
//  imem_req_valid  out  1  fetch request valid
//  imem_req_ready  in   1  memory accepts request this cycle
//  imem_req_addr   out  n  word address of request (bits[1:0]=0)
//  imem_rsp_valid  in   1  response data valid (in order, >=1 cycle after accept)
//  imem_rsp_data   in   n  fetched instruction word
//  redirect        in   1  PCSel from control: taken branch/jump this cycle
//  redirect_pc     in   n  redirect target
//  instr_valid     out  1  instr/instr_pc valid toward decode
//  instr_ready     in   1  decode consumes instr this cycle
//  instr           out  n  instruction word to control/decode
//  instr_pc        out  n  PC of instr
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   fetch_pc=RESET_PC; buffer empty; state=FETCH.
//   imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0 while rst high.
//  States: FETCH (request may be issued), WAIT (one request outstanding), DROP (outstanding response is wrong-path).
//  At most one request outstanding.
//   credit = (buffer count + (state!=FETCH)) < BUF_DEPTH.
//  FETCH:
//   imem_req_valid=credit; imem_req_addr=fetch_pc.
//   On valid&ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^n wrap), ->WAIT.
//  WAIT:
//   imem_req_valid=0.
//   On rsp_valid: push {req_pc,rsp_data}, ->FETCH.
//  DROP:
//   imem_req_valid=0.
//   On rsp_valid: discard data, ->FETCH.
//  imem_req_valid is registered-state based only; it never depends combinationally on redirect or imem_req_ready.
//  Output side:
//   instr_valid = buffer non-empty; instr/instr_pc = head entry (0 when empty).
//   Pop on instr_valid&instr_ready. Push and pop in the same cycle are both honoured.
//  Redirect (highest priority, any state):
//   - Buffer flushed; any same-cycle push/pop is ignored. instr_valid=0 from next cycle.
//   - fetch_pc <= {redirect_pc[n-1:2],2'b00}.
//   - FETCH with request accepted same cycle -> DROP. FETCH, no accept -> FETCH.
//   - WAIT with rsp_valid same cycle -> FETCH (data discarded). WAIT without rsp_valid -> DROP.
//   - DROP: stays DROP unless rsp_valid same cycle (then -> FETCH); fetch_pc still updated.
//  Latency (ready=1, 1-cycle memory):
//   - req accepted cycle t; rsp at t+1; instr_valid at t+2.
//   - Next request at t+2.
//   - Throughput 1 instr / 2 cycles.
//  Full buffer: no request issued until a pop frees credit; buffer never overflows.
//  Empty buffer: instr_valid=0; instr_ready ignored.
//  rst mid-operation: state discarded immediately; a late response arriving after reset is ignored (state=FETCH).
// TESTING
//  1. Release rst, ready=1, 1-cycle mem returning addr as data, instr_ready=1:
//     -> instr_pc sequence 0,4,8,C; instr_valid every other cycle starting 2 cycles after first accept.
//  2. instr_ready=0 for 10 cycles:
//     -> exactly BUF_DEPTH requests (0,4); req_valid stays 0.
//     Then ready=1 -> pops in order, fetch resumes at 8.
//  3. redirect=1, redirect_pc=0x100, while WAIT for addr 0x8:
//     -> response for 0x8 dropped; next request addr=0x100; first instr_pc=0x100; buffer flushed.
//  4. redirect with redirect_pc=0x203 in the same cycle as rsp_valid:
//     -> data not pushed; next req addr=0x200; no DROP cycle.
//  5. imem_req_ready=0 for 5 cycles:
//     -> req_valid held 1, addr stable.
//     Assert rst mid-WAIT -> next cycle req_valid=0, instr_valid=0; after release first addr=RESET_PC.
//  6. fetch_pc=0xFFFF_FFFC accepted -> next request addr=0x0000_0000 (wrap).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem requests,
// a small PC+word buffer toward decode, and redirect-driven wrong-path flushing.
module instr_fetch_unit #(
    parameter int            n         = 32,
    parameter logic [n-1:0]  RESET_PC  = '0,
    parameter int            BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [n-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [n-1:0] imem_rsp_data,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]    r_state;
    logic [n-1:0]  r_fetch_pc;
    logic [n-1:0]  r_req_pc;
    logic [n-1:0]  r_buf_pc   [BUF_DEPTH];
    logic [n-1:0]  r_buf_data [BUF_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_inflight;
    logic          w_credit;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [n-1:0]  w_target;

    // An outstanding request reserves a buffer slot, so a full buffer can never overflow.
    assign w_inflight = r_count + CW'(r_state != S_FETCH);
    assign w_credit   = w_inflight < CW'(BUF_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_target   = redirect_pc & ~{{(n-2){1'b0}}, 2'b11};

    assign imem_req_valid = !rst && (r_state == S_FETCH) && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_push = (r_state == S_WAIT) && imem_rsp_valid && !redirect;
    assign w_pop  = !w_empty && instr_ready && !redirect;

    assign instr_valid = !rst && !w_empty;
    assign instr       = instr_valid ? r_buf_data[r_rd_ptr] : '0;
    assign instr_pc    = instr_valid ? r_buf_pc[r_rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            case (r_state)
                S_FETCH: r_state <= w_accept ? S_DROP : S_FETCH;
                S_WAIT:  r_state <= imem_rsp_valid ? S_FETCH : S_DROP;
                S_DROP:  r_state <= imem_rsp_valid ? S_FETCH : S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        r_fetch_pc <= r_fetch_pc + n'(4);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT:  if (imem_rsp_valid) r_state <= S_FETCH;
                S_DROP:  if (imem_rsp_valid) r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Buffer contents and the in-flight PC carry no reset; occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept && !redirect) r_req_pc <= r_fetch_pc;
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
            r_buf_data[r_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a bench-side instruction memory plus a
// queue-based reference of the fetch front end, compared every cycle.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_unit #(.n(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: program counter, buffered {pc,word} entries, one in-flight slot.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_req_pc = '0;
    logic [63:0] m_q [$];
    bit          m_out = 1'b0;
    bit          m_wrong = 1'b0;

    // Bench memory: one pending request with a programmable response delay.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          lat_lo = 0;
    int          lat_hi = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit d_rst, input bit d_redir, input logic [31:0] d_rpc,
                         input bit d_rdy, input bit d_irdy);
        bit          exp_rv, exp_iv, rspv, dut_acc;
        logic [31:0] dut_addr;
        logic [63:0] head;
        @(negedge clk);
        rst            = d_rst;
        redirect       = d_redir;
        redirect_pc    = d_rpc;
        imem_req_ready = d_rdy;
        instr_ready    = d_irdy;
        rspv           = mem_busy && (mem_cnt == 0);
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspv ? mem_word(mem_addr) : $urandom;
        #1;
        exp_rv = !d_rst && !m_out && (m_q.size() < DEPTH);
        exp_iv = !d_rst && (m_q.size() > 0);
        head   = exp_iv ? m_q[0] : 64'd0;
        check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) check_eq("req_addr", imem_req_addr, m_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, exp_iv});
        check_eq("instr", instr, head[31:0]);
        check_eq("instr_pc", instr_pc, head[63:32]);
        dut_acc  = imem_req_valid && d_rdy;
        dut_addr = imem_req_addr;
        @(posedge clk);
        cyc++;
        if (d_rst) begin
            m_q.delete();
            m_pc = RST_PC; m_out = 1'b0; m_wrong = 1'b0;
        end else if (d_redir) begin
            m_q.delete();
            m_pc = {d_rpc[31:2], 2'b00};
            if (m_out) begin
                if (rspv) m_out = 1'b0; else m_wrong = 1'b1;
            end else if (exp_rv && d_rdy) begin
                m_out = 1'b1; m_wrong = 1'b1;
            end
        end else begin
            if (exp_iv && d_irdy) void'(m_q.pop_front());
            if (m_out && rspv) begin
                if (!m_wrong) m_q.push_back({m_req_pc, mem_word(m_req_pc)});
                m_out = 1'b0;
            end else if (exp_rv && d_rdy) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1'b1;
                m_wrong  = 1'b0;
            end
        end
        if (rspv) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (dut_acc) begin
            mem_busy = 1'b1;
            mem_addr = dut_addr;
            mem_cnt  = $urandom_range(lat_hi, lat_lo);
        end
        if (d_rst && mem_busy) mem_cnt = 0;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3, 0))
            0: return 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            1: return 32'($urandom_range(255, 0));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; instr_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        repeat (3) cycle(1, 0, 0, 1, 1);

        // Streaming with a one-cycle memory.
        lat_lo = 0; lat_hi = 0;
        repeat (12) cycle(0, 0, 0, 1, 1);

        // Decode stalls: buffer fills, then drains in order.
        repeat (12) cycle(0, 0, 0, 1, 0);
        repeat (8)  cycle(0, 0, 0, 1, 1);

        // Redirect while waiting on a slow response, then one coincident with a response.
        lat_lo = 2; lat_hi = 2;
        repeat (3) cycle(1, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 32'h0000_0100, 1, 1);
        repeat (10) cycle(0, 0, 0, 1, 1);
        lat_lo = 0; lat_hi = 0;
        repeat (2) cycle(1, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 32'h0000_0203, 1, 1);
        repeat (8) cycle(0, 0, 0, 1, 1);

        // Memory back-pressure, then reset while a request is in flight.
        lat_lo = 2; lat_hi = 2;
        repeat (2) cycle(0, 0, 0, 1, 1);
        repeat (5) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        repeat (8) cycle(0, 0, 0, 1, 1);

        // Address wrap at the top of the space.
        lat_lo = 0; lat_hi = 0;
        repeat (6) cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 32'hFFFF_FFFE, 0, 1);
        repeat (8) cycle(0, 0, 0, 1, 1);

        // Mixed random traffic.
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(99, 0) == 0,
                  $urandom_range(11, 0) == 0,
                  pick_target(),
                  $urandom_range(9, 0) < 7,
                  $urandom_range(9, 0) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
